// File: rtl/aes_axis_cmd_responder_pkg.sv
// rtl/aes_axis_cmd_responder_pkg.sv - command codes, constants and FSM states for the AES stream responder
package aes_axis_pkg;

    localparam logic [31:0] CMD_SET_KEY = 32'h0000_0010;
    localparam logic [31:0] CMD_ENCRYPT = 32'h0000_0020;
    localparam logic [31:0] CMD_DECRYPT = 32'h0000_0040;
    localparam logic [31:0] ERR_WORD    = 32'hFFFF_FFFF;
    localparam int          BLK_WORDS   = 4;

    typedef enum logic [1:0] {
        CMD,
        PAYLOAD,
        WAIT,
        SEND
    } state_e;

endpackage

// File: rtl/aes_axis_cmd_responder_if.sv
// rtl/aes_axis_cmd_responder_if.sv - 32-bit stream bundle with master/slave views
interface aes_axis_cmd_responder_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes_axis_serializer.sv
// rtl/aes_axis_serializer.sv - 128-to-32 response shift register driving the output stream
module aes_axis_serializer
    import aes_axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BLK_W  = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [BLK_W-1:0]         load_data_i,
    aes_axis_cmd_responder_if.master m_axis,
    output logic                     done_o
);

    logic [BLK_W-1:0] shreg_q, shreg_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             hs;

    assign hs = valid_q && m_axis.tready;

    // Load a new block, or advance one word per handshake; a stalled word stays put
    always_comb begin
        shreg_d = shreg_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = load_data_i;
            valid_d = 1'b1;
            last_d  = 1'b0;
            cnt_d   = '0;
        end else if (hs) begin
            shreg_d = shreg_q << DATA_W;
            cnt_d   = cnt_q + 2'd1;
            last_d  = (cnt_q == 2'(BLK_WORDS - 2));
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    // Output registers, cleared on reset so nothing is emitted until a fresh load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_axis.tdata  = shreg_q[BLK_W-1 -: DATA_W];
    assign m_axis.tvalid = valid_q;
    assign m_axis.tlast  = last_q;
    assign done_o        = hs && last_q;

endmodule

// File: rtl/aes_axis_cmd_responder.sv
// rtl/aes_axis_cmd_responder.sv - command/payload frame decoder driving the AES core and returning 4-word responses
module aes_axis_cmd_responder
    import aes_axis_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int BLK_W        = 128,
    parameter int CORE_TIMEOUT = 255
) (
    input  logic                     aclk,
    input  logic                     areset,
    aes_axis_cmd_responder_if.slave  s_axis,
    aes_axis_cmd_responder_if.master m_axis,
    output logic                     aes_start,
    output logic                     aes_decrypt,
    output logic [BLK_W-1:0]         aes_key,
    output logic [BLK_W-1:0]         aes_data,
    input  logic                     aes_done,
    input  logic [BLK_W-1:0]         aes_result
);

    localparam int TMO_W = $clog2(CORE_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      cmd_q, cmd_d;
    logic [BLK_W-1:0] staging_q, staging_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic             dec_q, dec_d;
    logic             start_q, start_d;
    logic             tready_q, tready_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             s_hs;
    logic [BLK_W-1:0] full_blk;
    logic             ser_load;
    logic [BLK_W-1:0] ser_blk;
    logic             ser_done;
    logic             unused_tlast;

    // Framing is purely by word count, so the incoming tlast carries no information
    assign unused_tlast = s_axis.tlast;

    // Frame decode, core handshake and timeout; response loads go straight into the serializer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        staging_d = staging_q;
        key_d     = key_q;
        data_d    = data_q;
        dec_d     = dec_q;
        start_d   = 1'b0;
        tmo_d     = tmo_q;
        ser_load  = 1'b0;
        ser_blk   = '0;
        s_hs      = s_axis.tvalid && tready_q;
        full_blk  = {staging_q[BLK_W-1:DATA_W], s_axis.tdata};

        unique case (state_q)
            CMD: begin
                if (s_hs) begin
                    cmd_d   = s_axis.tdata;
                    cnt_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (s_hs) begin
                    staging_d[(BLK_W-1) - DATA_W*int'(cnt_q) -: DATA_W] = s_axis.tdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(BLK_WORDS - 1)) begin
                        cnt_d = '0;
                        case (cmd_q)
                            CMD_SET_KEY: begin
                                key_d    = full_blk;
                                ser_load = 1'b1;
                                ser_blk  = '0;
                                state_d  = SEND;
                            end
                            CMD_ENCRYPT, CMD_DECRYPT: begin
                                data_d  = full_blk;
                                dec_d   = (cmd_q == CMD_DECRYPT);
                                start_d = 1'b1;
                                tmo_d   = '0;
                                state_d = WAIT;
                            end
                            default: begin
                                ser_load = 1'b1;
                                ser_blk  = {(BLK_W/DATA_W){ERR_WORD}};
                                state_d  = SEND;
                            end
                        endcase
                    end
                end
            end
            WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (aes_done) begin
                    ser_load = 1'b1;
                    ser_blk  = aes_result;
                    dec_d    = 1'b0;
                    state_d  = SEND;
                end else if (tmo_q == TMO_W'(CORE_TIMEOUT)) begin
                    ser_load = 1'b1;
                    ser_blk  = {(BLK_W/DATA_W){ERR_WORD}};
                    dec_d    = 1'b0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (ser_done) begin
                    state_d = CMD;
                end
            end
            default: state_d = CMD;
        endcase

        // Registered ready tracks the state being entered so it is low out of reset
        tready_d = (state_d == CMD) || (state_d == PAYLOAD);
    end

    // State and datapath registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= CMD;
            cnt_q     <= '0;
            cmd_q     <= '0;
            staging_q <= '0;
            key_q     <= '0;
            data_q    <= '0;
            dec_q     <= 1'b0;
            start_q   <= 1'b0;
            tready_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            staging_q <= staging_d;
            key_q     <= key_d;
            data_q    <= data_d;
            dec_q     <= dec_d;
            start_q   <= start_d;
            tready_q  <= tready_d;
            tmo_q     <= tmo_d;
        end
    end

    aes_axis_serializer #(
        .DATA_W (DATA_W),
        .BLK_W  (BLK_W)
    ) u_ser (
        .clk         (aclk),
        .rst         (areset),
        .load_i      (ser_load),
        .load_data_i (ser_blk),
        .m_axis      (m_axis),
        .done_o      (ser_done)
    );

    assign s_axis.tready = tready_q;
    assign aes_start     = start_q;
    assign aes_decrypt   = dec_q;
    assign aes_key       = key_q;
    assign aes_data      = data_q;

endmodule

// File: tb/tb_aes_axis_cmd_responder.sv
// tb/tb_aes_axis_cmd_responder.sv - self-checking bench for the AES stream command responder
module tb_aes_axis_cmd_responder;
    import aes_axis_pkg::*;

    localparam int          CORE_TIMEOUT = 255;
    localparam logic [127:0] KEY_K   = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] PT      = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] CT      = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] FB      = 128'h0BADF00D0BADF00D0BADF00D0BADF00D;
    localparam logic [127:0] ERR_BLK = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;

    typedef struct {
        logic [31:0]  cmd;
        logic [127:0] pay;
        bit           bp;
        logic [127:0] exp_resp;
        logic [127:0] exp_key;
        int           exp_starts;
        bit           exp_dec;
    } vec_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         aes_start;
    logic         aes_decrypt;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = '0;

    aes_axis_cmd_responder_if s_if ();
    aes_axis_cmd_responder_if m_if ();

    aes_axis_cmd_responder #(
        .DATA_W       (32),
        .BLK_W        (128),
        .CORE_TIMEOUT (CORE_TIMEOUT)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .aes_start   (aes_start),
        .aes_decrypt (aes_decrypt),
        .aes_key     (aes_key),
        .aes_data    (aes_data),
        .aes_done    (aes_done),
        .aes_result  (aes_result)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Core stand-in: knows the two reference AES vectors, anything else gets a marker value
    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] d, input logic dec);
        if (!dec && k == KEY_K && d == PT) return CT;
        if (dec && k == KEY_K && d == CT) return PT;
        return FB;
    endfunction

    bit           hang = 1'b0;
    bit           late_tgl = 1'b0;
    bit           late_seen = 1'b0;
    int           pend = 0;
    int           start_cnt = 0;
    logic [127:0] mkey = '0;
    logic [127:0] mdata = '0;
    logic         mdec = 1'b0;

    always @(posedge aclk) begin
        #1;
        aes_done = 1'b0;
        if (late_tgl != late_seen) begin
            late_seen  = late_tgl;
            aes_done   = 1'b1;
            aes_result = FB;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                aes_done   = 1'b1;
                aes_result = core_model(mkey, mdata, mdec);
            end
        end
        if (aes_start) begin
            start_cnt++;
            mkey  = aes_key;
            mdata = aes_data;
            mdec  = aes_decrypt;
            if (!hang) pend = 3;
        end
    end

    task automatic send_word(input logic [31:0] d);
        int n = 0;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        while (!s_if.tready && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        chk("s_handshake", s_if.tready, 1'b1);
        @(negedge aclk);
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] cmd, input logic [127:0] pay);
        send_word(cmd);
        for (int i = 0; i < 4; i++) send_word(pay[127-32*i -: 32]);
    endtask

    task automatic recv_resp(input bit bp, output logic [127:0] words, output logic [3:0] lasts,
                             output bit unstable, output bit busy_in, output bit tmo);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        words = '0; lasts = '0; unstable = 1'b0; busy_in = 1'b0;
        while (got < 4 && cyc < 4000) begin
            m_if.tready = bp ? ((cyc % 8) >= 2) : 1'b1;
            if (m_if.tvalid) begin
                if (stalled && (m_if.tdata !== pd || m_if.tlast !== pl)) unstable = 1'b1;
                if (s_if.tready) busy_in = 1'b1;
                if (m_if.tready) begin
                    words[127-32*got -: 32] = m_if.tdata;
                    lasts[got] = m_if.tlast;
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = m_if.tdata;
                    pl = m_if.tlast;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        m_if.tready = 1'b0;
        tmo = (got < 4);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0 = start_cnt;
        int n = 0;
        logic [127:0] words;
        logic [3:0] lasts;
        bit unstable, busy_in, tmo;
        send_frame(v.cmd, v.pay);
        if (v.exp_starts == 1) begin
            chk({tag, "_start_latency"}, aes_start, 1'b1);
            while (!aes_done && n < 100) begin
                @(negedge aclk);
                n++;
            end
            chk({tag, "_done_seen"}, aes_done, 1'b1);
            chk({tag, "_tvalid_before_done_edge"}, m_if.tvalid, 1'b0);
            @(negedge aclk);
            chk({tag, "_done_to_tvalid"}, m_if.tvalid, 1'b1);
            chk({tag, "_core_key"}, mkey, v.exp_key);
            chk({tag, "_core_data"}, mdata, v.pay);
            chk({tag, "_core_decrypt"}, mdec, v.exp_dec);
        end else begin
            chk({tag, "_resp_latency"}, m_if.tvalid, 1'b1);
            chk({tag, "_no_start"}, aes_start, 1'b0);
        end
        recv_resp(v.bp, words, lasts, unstable, busy_in, tmo);
        chk({tag, "_resp_timeout"}, tmo, 1'b0);
        chk({tag, "_resp_words"}, words, v.exp_resp);
        chk({tag, "_tlast_pattern"}, lasts, 4'b1000);
        chk({tag, "_stall_stable"}, unstable, 1'b0);
        chk({tag, "_s_tready_low_while_sending"}, busy_in, 1'b0);
        chk({tag, "_start_count"}, start_cnt - s0, v.exp_starts);
        chk({tag, "_key"}, aes_key, v.exp_key);
        chk({tag, "_cmd_ready_after"}, s_if.tready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        logic [127:0] words;
        logic [3:0] lasts;
        bit unstable, busy_in, tmo, spurious;
        int n, s0;

        vecs[0] = '{CMD_ENCRYPT, PT, 1'b0, FB, 128'h0, 1, 1'b0};
        vecs[1] = '{CMD_SET_KEY, KEY_K, 1'b0, 128'h0, KEY_K, 0, 1'b0};
        vecs[2] = '{CMD_ENCRYPT, PT, 1'b0, CT, KEY_K, 1, 1'b0};
        vecs[3] = '{CMD_ENCRYPT, PT, 1'b1, CT, KEY_K, 1, 1'b0};
        vecs[4] = '{32'h0000_0099, 128'h0123456789ABCDEF0011223344556677, 1'b0, ERR_BLK, KEY_K, 0, 1'b0};
        vecs[5] = '{CMD_ENCRYPT, PT, 1'b0, CT, KEY_K, 1, 1'b0};
        vecs[6] = '{CMD_DECRYPT, CT, 1'b1, PT, KEY_K, 1, 1'b1};

        s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0;

        repeat (3) @(negedge aclk);
        chk("reset_s_tready", s_if.tready, 1'b0);
        chk("reset_m_tvalid", m_if.tvalid, 1'b0);
        chk("reset_m_tlast", m_if.tlast, 1'b0);
        chk("reset_m_tdata", m_if.tdata, 32'h0);
        chk("reset_aes_start_decrypt", {aes_start, aes_decrypt}, 2'b00);
        chk("reset_aes_key", aes_key, 128'h0);
        chk("reset_aes_data", aes_data, 128'h0);
        areset = 1'b0;
        @(negedge aclk);
        chk("cmd_ready_after_reset", s_if.tready, 1'b1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Core never answers: error after the timeout, late done pulses ignored
        hang = 1'b1;
        s0 = start_cnt;
        send_frame(CMD_ENCRYPT, PT);
        n = 0;
        while (!m_if.tvalid && n < CORE_TIMEOUT + 50) begin
            @(negedge aclk);
            n++;
        end
        chk("hang_resp_arrives", m_if.tvalid, 1'b1);
        chk("hang_latency_window", (n >= CORE_TIMEOUT && n <= CORE_TIMEOUT + 3), 1'b1);
        late_tgl = ~late_tgl;
        repeat (4) @(negedge aclk);
        recv_resp(1'b0, words, lasts, unstable, busy_in, tmo);
        chk("hang_resp_timeout", tmo, 1'b0);
        chk("hang_resp_words", words, ERR_BLK);
        chk("hang_tlast_pattern", lasts, 4'b1000);
        chk("hang_start_count", start_cnt - s0, 1);
        late_tgl = ~late_tgl;
        m_if.tready = 1'b1;
        spurious = 1'b0;
        repeat (8) begin
            @(negedge aclk);
            if (m_if.tvalid) spurious = 1'b1;
        end
        m_if.tready = 1'b0;
        chk("late_done_idle_no_output", spurious, 1'b0);
        hang = 1'b0;

        // Reset after two payload words of a new key
        send_word(CMD_SET_KEY);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        areset = 1'b1;
        #1;
        chk("midreset_s_tready", s_if.tready, 1'b0);
        chk("midreset_m_outputs", {m_if.tvalid, m_if.tlast, m_if.tdata}, 34'h0);
        chk("midreset_aes_start_decrypt", {aes_start, aes_decrypt}, 2'b00);
        chk("midreset_aes_key", aes_key, 128'h0);
        chk("midreset_aes_data", aes_data, 128'h0);
        @(negedge aclk);
        areset = 1'b0;
        m_if.tready = 1'b1;
        spurious = 1'b0;
        repeat (10) begin
            @(negedge aclk);
            if (m_if.tvalid) spurious = 1'b1;
        end
        m_if.tready = 1'b0;
        chk("midreset_no_response", spurious, 1'b0);
        run_vec(vecs[1], "post_reset_setkey");
        run_vec(vecs[2], "post_reset_encrypt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
